// File: rtl/dmem_bus_bridge.sv
// Load/store-stage to request/grant/response data-bus bridge with registered read data.
// Optional posted single-entry store buffer: define DMEM_BRIDGE_POSTED_WRITE_EN.
module dmem_bus_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_latch;
  logic        w_posted_accept;
  logic        w_resp;
  logic        r_posted;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_mem_rdata;

`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
  assign w_posted_accept = (r_state == S_IDLE) && mem_en && (|mem_wen);
`else
  assign w_posted_accept = 1'b0;
`endif

  assign w_resp = (r_state == S_WAIT) && bus_rvalid;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_en) begin
          w_latch     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ:   if (bus_gnt) w_state_nxt = S_WAIT;
      S_WAIT:  if (bus_rvalid) w_state_nxt = r_posted ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_posted    <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'h0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_mem_rdata <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_req <= (w_state_nxt == S_REQ);
      if (w_latch) begin
        r_posted    <= w_posted_accept;
        r_bus_we    <= |mem_wen;
        r_bus_be    <= (|mem_wen) ? mem_wen : 4'hF;
        r_bus_addr  <= mem_addr;
        r_bus_wdata <= mem_wdata;
      end else if (w_resp) begin
        r_posted <= 1'b0;
      end
      // Write acks carry no data; only a load response updates the returned word.
      if (w_resp && !r_bus_we) r_mem_rdata <= bus_rdata;
    end
  end

  assign stall     = mem_en && (r_state != S_DONE) && !w_posted_accept;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_be    = r_bus_be;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed self-checking bench for dmem_bus_bridge; covers the posted-store path when
// DMEM_BRIDGE_POSTED_WRITE_EN is defined.
module tb_dmem_bus_bridge;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  dmem_bus_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with the bridge in IDLE. Presents one access and plays the
  // bus: grant after gnt_dly cycles of bus_req, response rv_dly cycles into WAIT. Returns when
  // stall falls, leaving the caller just after the falling edge of that cycle.
  task automatic run_access(input logic [31:0] addr, input logic [3:0] wen,
                            input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata, output int n_stall, output int n_req);
    int n_wait;
    bit granted, answered, done, unstable;
    n_stall = 0; n_req = 0; n_wait = 0;
    granted = 0; answered = 0; done = 0; unstable = 0;
    mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (!stall) begin
        done = 1;
      end else begin
        n_stall++;
        if (bus_req) begin
          if (bus_addr !== addr || bus_we !== (|wen) || bus_wdata !== wdata ||
              bus_be !== ((wen == 4'h0) ? 4'hF : wen)) unstable = 1;
          if (n_req == gnt_dly) begin
            bus_gnt = 1'b1;
            granted = 1;
          end
          n_req++;
        end else if (granted && !answered) begin
          if (n_wait == rv_dly) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rdata;
            answered   = 1;
          end
          n_wait++;
        end
        @(negedge clk);
      end
    end
    check("access_completes", 32'(done), 32'd1);
    check("req_fields", 32'(unstable), 32'd0);
  endtask

  initial begin
    int ns, nr, bad_req, bad_stall;
    rst = 1'b1; mem_en = 1'b0; mem_wen = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

    // Reset values
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    #1 rst = 1'b0;

    // Minimum-latency load
    @(negedge clk);
    run_access(32'h1000_0004, 4'h0, 32'h0, 0, 0, 32'hDEAD_BEEF, ns, nr);
    check("load_stall_cycles", 32'(ns), 32'd3);
    check("load_req_cycles", 32'(nr), 32'd1);
    check("load_rdata", mem_rdata, 32'hDEAD_BEEF);

`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
    // Posted store followed immediately by a load
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 4'hF; mem_addr = 32'h3000_0000; mem_wdata = 32'hA5A5_5A5A;
    #1;
    check("post_stall_T", 32'(stall), 32'd0);
    @(negedge clk);
    mem_wen = 4'h0; mem_addr = 32'h3000_0010; mem_wdata = 32'h0;
    #1;
    check("post_load_stall_req", 32'(stall), 32'd1);
    check("post_store_req", 32'(bus_req), 32'd1);
    check("post_store_we", 32'(bus_we), 32'd1);
    check("post_store_addr", bus_addr, 32'h3000_0000);
    check("post_store_wdata", bus_wdata, 32'hA5A5_5A5A);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    check("post_load_stall_wait", 32'(stall), 32'd1);
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("post_store_no_rdata", mem_rdata, 32'hDEAD_BEEF);
    run_access(32'h3000_0010, 4'h0, 32'h0, 0, 0, 32'hCAFE_F00D, ns, nr);
    check("post_load_stall_cycles", 32'(ns), 32'd3);
    check("post_load_req_cycles", 32'(nr), 32'd1);
    check("post_load_rdata", mem_rdata, 32'hCAFE_F00D);
`else
    // Store with grant delayed by three cycles
    @(negedge clk);
    run_access(32'h2000_0008, 4'b0100, 32'h00AB_0000, 3, 0, 32'h0BAD_0BAD, ns, nr);
    check("store_stall_cycles", 32'(ns), 32'd6);
    check("store_req_cycles", 32'(nr), 32'd4);
    check("store_keeps_rdata", mem_rdata, 32'hDEAD_BEEF);
`endif

    // Back-to-back loads, then confirm nothing is re-issued
    @(negedge clk);
    run_access(32'h0000_0000, 4'h0, 32'h0, 0, 0, 32'h1111_1111, ns, nr);
    check("b2b0_req_cycles", 32'(nr), 32'd1);
    check("b2b0_rdata", mem_rdata, 32'h1111_1111);
    @(negedge clk);
    run_access(32'h0000_0004, 4'h0, 32'h0, 0, 0, 32'h2222_2222, ns, nr);
    check("b2b1_req_cycles", 32'(nr), 32'd1);
    check("b2b1_rdata", mem_rdata, 32'h2222_2222);
    @(negedge clk);
    mem_en = 1'b0;
    bad_req = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (bus_req) bad_req++;
      @(negedge clk);
    end
    check("b2b_no_duplicate", 32'(bad_req), 32'd0);

    // Idle with noise on the bus
    bad_req = 0; bad_stall = 0;
    for (int i = 0; i < 10; i++) begin
      bus_gnt = 1'($urandom_range(1)); bus_rvalid = 1'($urandom_range(1)); bus_rdata = $urandom;
      #1;
      if (bus_req) bad_req++;
      if (stall) bad_stall++;
      @(negedge clk);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    check("idle_req", 32'(bad_req), 32'd0);
    check("idle_stall", 32'(bad_stall), 32'd0);
    check("idle_rdata", mem_rdata, 32'h2222_2222);

    // Reset while in WAIT, then a late response
    mem_en = 1'b1; mem_wen = 4'h0; mem_addr = 32'h4000_0000;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; mem_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", 32'(bus_req), 32'd0);
    check("rst_mid_rdata", mem_rdata, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check("late_rvalid_rdata", mem_rdata, 32'h0);
    check("late_rvalid_req", 32'(bus_req), 32'd0);

    // Delayed grant and response after reset: back in IDLE, one extra cycle per delay cycle
    @(negedge clk);
    run_access(32'h0000_0008, 4'h0, 32'h0, 1, 2, 32'h5555_AAAA, ns, nr);
    check("dly_stall_cycles", 32'(ns), 32'd6);
    check("dly_req_cycles", 32'(nr), 32'd2);
    check("dly_rdata", mem_rdata, 32'h5555_AAAA);
    @(negedge clk);
    mem_en = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
